// File: rtl/pcie_pkg.sv
// Shared types for the PCIe transaction-layer TX path.
// FSM states, header field offsets and the output beat bundle.
package pcie_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } tx_state_t;

    localparam int LEN_L_LSB = 24;
    localparam int LEN_L_MSB = 31;
    localparam int LEN_H_LSB = 16;
    localparam int LEN_H_MSB = 17;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
    } tlp_beat_t;

    // Data beats after the header, minus one; a zero length field means 1024 DW.
    function automatic logic [7:0] p_beat_cnt(input logic [127:0] hdr);
        logic [9:0]  len;
        logic [10:0] dw;
        len = {hdr[LEN_H_MSB:LEN_H_LSB], hdr[LEN_L_MSB:LEN_L_LSB]};
        dw  = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        dw  = dw - 11'd1;
        return dw[10:3];
    endfunction

endpackage

// File: rtl/tl_rr_arb2.sv
// Two-requester round-robin arbiter (P vs NP).
// The last-grant flop gives NP priority right after a P grant.
module tl_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_p,
    input  logic req_np,
    output logic gnt_p,
    output logic gnt_np
);

    logic last_p;

    always_comb begin
        gnt_p  = 1'b0;
        gnt_np = 1'b0;
        if (en) begin
            unique case (1'b1)
                (req_p & req_np): begin
                    gnt_np = last_p;
                    gnt_p  = !last_p;
                end
                (req_p & !req_np): gnt_p  = 1'b1;
                (!req_p & req_np): gnt_np = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_p <= 1'b0;
        end else if (gnt_p) begin
            last_p <= 1'b1;
        end else if (gnt_np) begin
            last_p <= 1'b0;
        end
    end

endmodule

// File: rtl/tl_tx_arb.sv
// TLP transmit arbiter: merges NP and P header/data FIFOs
// into a single registered 256-bit beat stream.
module tl_tx_arb
    import pcie_pkg::*;
#(
    parameter int TX_DEPTH_LG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    np_hdr_empty_i,
    input  logic [127:0]            np_hdr_rdata_i,
    output logic                    np_hdr_rden_o,
    input  logic                    p_hdr_empty_i,
    input  logic [127:0]            p_hdr_rdata_i,
    output logic                    p_hdr_rden_o,
    input  logic                    p_data_empty_i,
    input  logic [255:0]            p_data_rdata_i,
    output logic                    p_data_rden_o,
    input  logic [TX_DEPTH_LG2-1:0] p_payload_cnt_i,
    output logic                    p_sent_o,
    output logic                    tlp_valid_o,
    input  logic                    tlp_ready_i,
    output logic [255:0]            tlp_data_o,
    output logic                    tlp_sop_o,
    output logic                    tlp_eop_o
);

    tx_state_t state, state_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    tlp_beat_t  beat_nx;
    logic       load;
    logic       load_ok;
    logic       p_elig, np_elig;
    logic       arb_en;
    logic       gnt_p, gnt_np;

    assign load_ok = !tlp_valid_o | tlp_ready_i;
    assign p_elig  = !p_hdr_empty_i && (p_payload_cnt_i != '0);
    assign np_elig = !np_hdr_empty_i;
    // Gated by rst so no pop leaks out while the FIFOs are being cleared.
    assign arb_en  = (state == IDLE) && load_ok && !rst;

    tl_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req_p  (p_elig),
        .req_np (np_elig),
        .gnt_p  (gnt_p),
        .gnt_np (gnt_np)
    );

    assign np_hdr_rden_o = gnt_np;
    assign p_hdr_rden_o  = gnt_p;

    always_comb begin
        state_nx      = state;
        beat_cnt_nx   = beat_cnt;
        beat_nx       = '0;
        load          = 1'b0;
        p_data_rden_o = 1'b0;
        p_sent_o      = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_np) begin
                    load         = 1'b1;
                    beat_nx.data = {128'd0, np_hdr_rdata_i};
                    beat_nx.sop  = 1'b1;
                    beat_nx.eop  = 1'b1;
                end else if (gnt_p) begin
                    load         = 1'b1;
                    beat_nx.data = {128'd0, p_hdr_rdata_i};
                    beat_nx.sop  = 1'b1;
                    beat_cnt_nx  = p_beat_cnt(p_hdr_rdata_i);
                    state_nx     = DATA;
                end
            end
            DATA: begin
                if (load_ok && !p_data_empty_i) begin
                    p_data_rden_o = 1'b1;
                    load          = 1'b1;
                    beat_nx.data  = p_data_rdata_i;
                    beat_nx.eop   = (beat_cnt == 8'd0);
                    if (beat_cnt == 8'd0) begin
                        p_sent_o = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        beat_cnt_nx = beat_cnt - 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlp_valid_o <= 1'b0;
            tlp_data_o  <= '0;
            tlp_sop_o   <= 1'b0;
            tlp_eop_o   <= 1'b0;
        end else if (load) begin
            tlp_valid_o <= 1'b1;
            tlp_data_o  <= beat_nx.data;
            tlp_sop_o   <= beat_nx.sop;
            tlp_eop_o   <= beat_nx.eop;
        end else if (tlp_ready_i) begin
            tlp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tl_tx_arb.sv
// Directed bench for tl_tx_arb with queue-backed show-ahead FIFOs.
// Beats are captured at the falling edge when valid and ready.
module tb_tl_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         np_hdr_empty_i;
    logic [127:0] np_hdr_rdata_i;
    logic         np_hdr_rden_o;
    logic         p_hdr_empty_i;
    logic [127:0] p_hdr_rdata_i;
    logic         p_hdr_rden_o;
    logic         p_data_empty_i;
    logic [255:0] p_data_rdata_i;
    logic         p_data_rden_o;
    logic [2:0]   p_payload_cnt_i;
    logic         p_sent_o;
    logic         tlp_valid_o;
    logic         tlp_ready_i;
    logic [255:0] tlp_data_o;
    logic         tlp_sop_o;
    logic         tlp_eop_o;

    tl_tx_arb #(.TX_DEPTH_LG2(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .np_hdr_empty_i  (np_hdr_empty_i),
        .np_hdr_rdata_i  (np_hdr_rdata_i),
        .np_hdr_rden_o   (np_hdr_rden_o),
        .p_hdr_empty_i   (p_hdr_empty_i),
        .p_hdr_rdata_i   (p_hdr_rdata_i),
        .p_hdr_rden_o    (p_hdr_rden_o),
        .p_data_empty_i  (p_data_empty_i),
        .p_data_rdata_i  (p_data_rdata_i),
        .p_data_rden_o   (p_data_rden_o),
        .p_payload_cnt_i (p_payload_cnt_i),
        .p_sent_o        (p_sent_o),
        .tlp_valid_o     (tlp_valid_o),
        .tlp_ready_i     (tlp_ready_i),
        .tlp_data_o      (tlp_data_o),
        .tlp_sop_o       (tlp_sop_o),
        .tlp_eop_o       (tlp_eop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic         sop;
        logic         eop;
    } rx_t;

    logic [127:0] np_q[$];
    logic [127:0] ph_q[$];
    logic [255:0] pd_q[$];
    rx_t          rx_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int np_pops, ph_pops, pd_pops, sent_cnt, multi_rden, sent_eop_bad;

    function automatic logic [127:0] mk_hdr(input logic [9:0] len,
                                            input logic [7:0] tag);
        logic [127:0] h;
        h = {4{tag, 24'hA5C300}};
        h[31:24] = len[7:0];
        h[17:16] = len[9:8];
        return h;
    endfunction

    function automatic logic [255:0] mk_data(input logic [7:0] tag,
                                             input logic [7:0] idx);
        return {8{tag, idx, 16'h3C5A}};
    endfunction

    task automatic refresh();
        np_hdr_empty_i = (np_q.size() == 0);
        np_hdr_rdata_i = np_hdr_empty_i ? '0 : np_q[0];
        p_hdr_empty_i  = (ph_q.size() == 0);
        p_hdr_rdata_i  = p_hdr_empty_i ? '0 : ph_q[0];
        p_data_empty_i = (pd_q.size() == 0);
        p_data_rdata_i = p_data_empty_i ? '0 : pd_q[0];
    endtask

    task automatic clear_stats();
        np_pops = 0; ph_pops = 0; pd_pops = 0;
        sent_cnt = 0; multi_rden = 0; sent_eop_bad = 0;
        rx_q.delete();
    endtask

    task automatic tick();
        logic a, b, c, s;
        rx_t  r;
        @(negedge clk);
        a = np_hdr_rden_o;
        b = p_hdr_rden_o;
        c = p_data_rden_o;
        s = p_sent_o;
        if (tlp_valid_o && tlp_ready_i) begin
            r.d = tlp_data_o; r.sop = tlp_sop_o; r.eop = tlp_eop_o;
            rx_q.push_back(r);
        end
        if (int'(a) + int'(b) + int'(c) > 1) multi_rden++;
        @(posedge clk);
        #1;
        if (a && np_q.size() > 0) begin void'(np_q.pop_front()); np_pops++; end
        if (b && ph_q.size() > 0) begin void'(ph_q.pop_front()); ph_pops++; end
        if (c && pd_q.size() > 0) begin void'(pd_q.pop_front()); pd_pops++; end
        if (s) begin
            sent_cnt++;
            if (!(tlp_valid_o && tlp_eop_o)) sent_eop_bad++;
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        np_q.delete(); ph_q.delete(); pd_q.delete();
        p_payload_cnt_i = '0;
        tlp_ready_i = 1'b1;
        refresh();
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_stats();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tlp_ready_i = 1'b1;
        p_payload_cnt_i = 3'd1;
        np_q.push_back(mk_hdr(10'd4, 8'h01));
        ph_q.push_back(mk_hdr(10'd8, 8'h02));
        refresh();
        @(negedge clk);
        n_tests++;
        if ({tlp_valid_o, tlp_sop_o, tlp_eop_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000",
                     {tlp_valid_o, tlp_sop_o, tlp_eop_o});
        end
        n_tests++;
        if (tlp_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", tlp_data_o);
        end
        n_tests++;
        if ({np_hdr_rden_o, p_hdr_rden_o, p_data_rden_o, p_sent_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_rden: got %b want 0000",
                     {np_hdr_rden_o, p_hdr_rden_o, p_data_rden_o, p_sent_o});
        end
        do_reset();
    endtask

    task automatic test_np_only();
        logic [127:0] h;
        do_reset();
        h = mk_hdr(10'd16, 8'h11);
        np_q.push_back(h);
        refresh();
        repeat (4) tick();
        n_tests++;
        if (rx_q.size() !== 1) begin
            n_fail++;
            $display("FAIL np_only_beats: got %0d want 1", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[0].d !== {128'd0, h} || !rx_q[0].sop || !rx_q[0].eop) begin
                n_fail++;
                $display("FAIL np_only_beat: got %h s%b e%b want %h s1 e1",
                         rx_q[0].d, rx_q[0].sop, rx_q[0].eop, {128'd0, h});
            end
        end
        n_tests++;
        if (np_pops !== 1 || sent_cnt !== 0 || tlp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL np_only_side: pops %0d sent %0d valid %b want 1 0 0",
                     np_pops, sent_cnt, tlp_valid_o);
        end
    endtask

    task automatic test_p_basic();
        logic [127:0] h;
        logic [255:0] d[3];
        logic [255:0] ed;
        do_reset();
        h = mk_hdr(10'd24, 8'h22);
        ph_q.push_back(h);
        for (int i = 0; i < 3; i++) begin
            d[i] = mk_data(8'h22, 8'(i));
            pd_q.push_back(d[i]);
        end
        p_payload_cnt_i = 3'd1;
        refresh();
        tick();
        n_tests++;
        if (!tlp_valid_o || !tlp_sop_o || tlp_eop_o || tlp_data_o !== {128'd0, h}) begin
            n_fail++;
            $display("FAIL p_first: v%b s%b e%b d %h want v1 s1 e0 hdr",
                     tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_data_o);
        end
        repeat (3) tick();
        n_tests++;
        if (!tlp_valid_o || !tlp_eop_o || tlp_data_o !== d[2] || sent_cnt !== 1) begin
            n_fail++;
            $display("FAIL p_last_at_4: v%b e%b sent %0d want v1 e1 sent 1",
                     tlp_valid_o, tlp_eop_o, sent_cnt);
        end
        repeat (3) tick();
        n_tests++;
        if (rx_q.size() !== 4) begin
            n_fail++;
            $display("FAIL p_beats: got %0d want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ed = (i == 0) ? {128'd0, h} : d[i-1];
                n_tests++;
                if (rx_q[i].d !== ed || rx_q[i].sop !== (i == 0) ||
                    rx_q[i].eop !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL p_beat%0d: got %h s%b e%b want %h", i,
                             rx_q[i].d, rx_q[i].sop, rx_q[i].eop, ed);
                end
            end
        end
        n_tests++;
        if (pd_pops !== 3 || ph_pops !== 1 || sent_cnt !== 1 || sent_eop_bad !== 0) begin
            n_fail++;
            $display("FAIL p_side: dpops %0d hpops %0d sent %0d bad %0d want 3 1 1 0",
                     pd_pops, ph_pops, sent_cnt, sent_eop_bad);
        end
    endtask

    task automatic test_np_before_p();
        logic [127:0] hp, hn;
        logic [255:0] d;
        do_reset();
        hp = mk_hdr(10'd8, 8'h33);
        hn = mk_hdr(10'd4, 8'h44);
        d  = mk_data(8'h33, 8'd0);
        ph_q.push_back(hp);
        pd_q.push_back(d);
        np_q.push_back(hn);
        refresh();
        repeat (3) tick();
        n_tests++;
        if (rx_q.size() !== 1 || ph_pops !== 0) begin
            n_fail++;
            $display("FAIL npfirst_wait: beats %0d hpops %0d want 1 0",
                     rx_q.size(), ph_pops);
        end else begin
            n_tests++;
            if (rx_q[0].d !== {128'd0, hn} || !rx_q[0].eop) begin
                n_fail++;
                $display("FAIL npfirst_beat: got %h want %h", rx_q[0].d, {128'd0, hn});
            end
        end
        p_payload_cnt_i = 3'd1;
        repeat (4) tick();
        n_tests++;
        if (rx_q.size() !== 3) begin
            n_fail++;
            $display("FAIL npfirst_p_beats: got %0d want 3", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[1].d !== {128'd0, hp} || !rx_q[1].sop || rx_q[1].eop ||
                rx_q[2].d !== d || rx_q[2].sop || !rx_q[2].eop || sent_cnt !== 1) begin
                n_fail++;
                $display("FAIL npfirst_p: b1 %h b2 %h sent %0d want hdr data 1",
                         rx_q[1].d, rx_q[2].d, sent_cnt);
            end
        end
    endtask

    task automatic test_alternate();
        rx_t e[6];
        do_reset();
        ph_q.push_back(mk_hdr(10'd8, 8'h51));
        ph_q.push_back(mk_hdr(10'd8, 8'h52));
        pd_q.push_back(mk_data(8'h51, 8'd0));
        pd_q.push_back(mk_data(8'h52, 8'd0));
        np_q.push_back(mk_hdr(10'd4, 8'h61));
        np_q.push_back(mk_hdr(10'd4, 8'h62));
        p_payload_cnt_i = 3'd2;
        refresh();
        e[0] = '{{128'd0, mk_hdr(10'd8, 8'h51)}, 1'b1, 1'b0};
        e[1] = '{mk_data(8'h51, 8'd0), 1'b0, 1'b1};
        e[2] = '{{128'd0, mk_hdr(10'd4, 8'h61)}, 1'b1, 1'b1};
        e[3] = '{{128'd0, mk_hdr(10'd8, 8'h52)}, 1'b1, 1'b0};
        e[4] = '{mk_data(8'h52, 8'd0), 1'b0, 1'b1};
        e[5] = '{{128'd0, mk_hdr(10'd4, 8'h62)}, 1'b1, 1'b1};
        repeat (7) tick();
        n_tests++;
        if (rx_q.size() !== 6 || multi_rden !== 0) begin
            n_fail++;
            $display("FAIL alt_count: beats %0d multi %0d want 6 0",
                     rx_q.size(), multi_rden);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (rx_q[i].d !== e[i].d || rx_q[i].sop !== e[i].sop ||
                    rx_q[i].eop !== e[i].eop) begin
                    n_fail++;
                    $display("FAIL alt_beat%0d: got %h s%b e%b want %h s%b e%b", i,
                             rx_q[i].d, rx_q[i].sop, rx_q[i].eop,
                             e[i].d, e[i].sop, e[i].eop);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] h;
        logic [255:0] d[3];
        logic [255:0] ed;
        do_reset();
        h = mk_hdr(10'd24, 8'h71);
        ph_q.push_back(h);
        for (int i = 0; i < 3; i++) begin
            d[i] = mk_data(8'h71, 8'(i));
            pd_q.push_back(d[i]);
        end
        p_payload_cnt_i = 3'd1;
        refresh();
        repeat (2) tick();
        tlp_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (!tlp_valid_o || tlp_data_o !== d[0] || tlp_sop_o || tlp_eop_o ||
                pd_pops !== 1 || ph_pops !== 1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: v%b d %h dpops %0d want v1 d0 1",
                         k, tlp_valid_o, tlp_data_o, pd_pops);
            end
        end
        tlp_ready_i = 1'b1;
        repeat (6) tick();
        n_tests++;
        if (rx_q.size() !== 4 || pd_pops !== 3) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d dpops %0d want 4 3",
                     rx_q.size(), pd_pops);
        end else begin
            for (int i = 0; i < 4; i++) begin
                ed = (i == 0) ? {128'd0, h} : d[i-1];
                n_tests++;
                if (rx_q[i].d !== ed || rx_q[i].eop !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL stall_beat%0d: got %h want %h", i, rx_q[i].d, ed);
                end
            end
        end
    endtask

    task automatic test_starve();
        logic [255:0] d0, d1;
        do_reset();
        d0 = mk_data(8'h81, 8'd0);
        d1 = mk_data(8'h81, 8'd1);
        ph_q.push_back(mk_hdr(10'd16, 8'h81));
        pd_q.push_back(d0);
        p_payload_cnt_i = 3'd1;
        refresh();
        repeat (4) tick();
        n_tests++;
        if (tlp_valid_o !== 1'b0 || rx_q.size() !== 2 || sent_cnt !== 0 || pd_pops !== 1) begin
            n_fail++;
            $display("FAIL starve_gap: v%b beats %0d sent %0d want 0 2 0",
                     tlp_valid_o, rx_q.size(), sent_cnt);
        end
        pd_q.push_back(d1);
        refresh();
        repeat (3) tick();
        n_tests++;
        if (rx_q.size() !== 3) begin
            n_fail++;
            $display("FAIL starve_resume: beats %0d want 3", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[2].d !== d1 || !rx_q[2].eop || sent_cnt !== 1) begin
                n_fail++;
                $display("FAIL starve_last: got %h e%b sent %0d want d1 e1 1",
                         rx_q[2].d, rx_q[2].eop, sent_cnt);
            end
        end
    endtask

    task automatic test_lengths();
        int lens[3] = '{0, 1, 257};
        int nbs[3]  = '{128, 1, 33};
        int neop;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            ph_q.push_back(mk_hdr(10'(lens[t]), 8'h90));
            for (int i = 0; i < nbs[t]; i++) pd_q.push_back(mk_data(8'h90, 8'(i)));
            p_payload_cnt_i = 3'd1;
            refresh();
            repeat (nbs[t] + 4) tick();
            neop = 0;
            foreach (rx_q[i]) if (rx_q[i].eop) neop++;
            n_tests++;
            if (rx_q.size() !== nbs[t] + 1 || pd_pops !== nbs[t] || neop !== 1 ||
                sent_cnt !== 1 || (rx_q.size() > 0 && !rx_q[rx_q.size()-1].eop)) begin
                n_fail++;
                $display("FAIL len%0d: beats %0d dpops %0d eops %0d sent %0d want %0d %0d 1 1",
                         lens[t], rx_q.size(), pd_pops, neop, sent_cnt,
                         nbs[t] + 1, nbs[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] hn;
        do_reset();
        ph_q.push_back(mk_hdr(10'd24, 8'hA1));
        for (int i = 0; i < 3; i++) pd_q.push_back(mk_data(8'hA1, 8'(i)));
        p_payload_cnt_i = 3'd1;
        refresh();
        repeat (2) tick();
        n_tests++;
        if (tlp_data_o !== mk_data(8'hA1, 8'd0)) begin
            n_fail++;
            $display("FAIL rmid_beat2: got %h want data0", tlp_data_o);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({tlp_valid_o, tlp_sop_o, tlp_eop_o, np_hdr_rden_o, p_hdr_rden_o,
             p_data_rden_o, p_sent_o} !== 7'b0 || tlp_data_o !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear: v%b s%b e%b d %h want all 0",
                     tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_data_o);
        end
        np_q.delete(); ph_q.delete(); pd_q.delete();
        p_payload_cnt_i = '0;
        refresh();
        tick();
        rst = 1'b0;
        clear_stats();
        repeat (3) tick();
        n_tests++;
        if (rx_q.size() !== 0 || tlp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_partial: beats %0d v%b want 0 0", rx_q.size(), tlp_valid_o);
        end
        hn = mk_hdr(10'd4, 8'hB2);
        np_q.push_back(hn);
        refresh();
        tick();
        n_tests++;
        if (!tlp_valid_o || !tlp_sop_o || tlp_data_o !== {128'd0, hn}) begin
            n_fail++;
            $display("FAIL rmid_sop: v%b s%b d %h want v1 s1 hdr",
                     tlp_valid_o, tlp_sop_o, tlp_data_o);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_np_only();
        test_p_basic();
        test_np_before_p();
        test_alternate();
        test_stall();
        test_starve();
        test_lengths();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
